// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: ALU_Control load/store codes, FSM
// states and the big-endian lane helpers used by mem_align.
package mem_access_pkg;

    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h23;
    localparam logic [5:0] ALU_LBU = 6'h24;
    localparam logic [5:0] ALU_LHU = 6'h25;
    localparam logic [5:0] ALU_SB  = 6'h28;
    localparam logic [5:0] ALU_SH  = 6'h29;
    localparam logic [5:0] ALU_SW  = 6'h2B;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;

    // Unknown codes fall through to a full-word access.
    function automatic mem_size_t decode_size(input logic [5:0] ctrl);
        case (ctrl)
            ALU_LB, ALU_LBU, ALU_SB: decode_size = SZ_BYTE;
            ALU_LH, ALU_LHU, ALU_SH: decode_size = SZ_HALF;
            default:                 decode_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic load_is_signed(input logic [5:0] ctrl);
        load_is_signed = (ctrl == ALU_LB) || (ctrl == ALU_LH);
    endfunction

    function automatic logic [3:0] lane_be(input mem_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: lane_be = 4'b1000 >> off;
            SZ_HALF: lane_be = off[1] ? 4'b0011 : 4'b1100;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Offset 0 is the most significant lane (big-endian).
    function automatic logic [31:0] lane_extract(input mem_size_t sz, input logic sext,
                                                 input logic [1:0] off, input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = data[31:24];
            2'd1:    b = data[23:16];
            2'd2:    b = data[15:8];
            default: b = data[7:0];
        endcase
        h = off[1] ? data[15:0] : data[31:16];
        case (sz)
            SZ_BYTE: lane_extract = {{24{sext & b[7]}}, b};
            SZ_HALF: lane_extract = {{16{sext & h[15]}}, h};
            default: lane_extract = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane steering for data memory: store replication and byte
// enables, load extract/extend, and misalignment detection.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [5:0]  alu_ctrl,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data,
    output logic        misaligned
);

    mem_size_t mem_size;

    always_comb begin
        mem_size    = decode_size(alu_ctrl);
        byte_en     = lane_be(mem_size, offset);
        store_lanes = store_data;
        misaligned  = 1'b0;
        case (mem_size)
            SZ_BYTE: store_lanes = {4{store_data[7:0]}};
            SZ_HALF: begin
                store_lanes = {2{store_data[15:0]}};
                misaligned  = offset[0];
            end
            default: misaligned = (offset != 2'b00);
        endcase
        load_data = lane_extract(mem_size, load_is_signed(alu_ctrl), offset, load_raw);
    end

endmodule

// File: rtl/mem_access.sv
// Pipeline MEM stage: issues loads/stores over a req/ack handshake, stalls
// upstream while waiting, aborts on misalignment or timeout, registers to WB.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    input  logic [1:0]  MEM_Data_select,
    input  logic [31:0] WB_result_forward,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        STALL_OUT,
    output logic        FAULT_OUT,
    output logic [31:0] Mem_result_forward,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [31:0] WriteData1_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic        RegWrite1_OUT
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      instr_q, instr_d, pc_q, pc_d, wdata_q, wdata_d;
    logic [4:0]       wreg_q, wreg_d;
    logic             regwrite_q, regwrite_d;

    logic        mem_op, is_store, is_load, timeout, req, complete, pass;
    logic [31:0] store_src, store_lanes, load_data;
    logic [3:0]  byte_en;
    logic        misaligned;

    mem_align u_align (
        .alu_ctrl    (ALU_Control1_IN),
        .offset      (ALU_result1_IN[1:0]),
        .store_data  (store_src),
        .load_raw    (dmem_rdata),
        .byte_en     (byte_en),
        .store_lanes (store_lanes),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    always_comb begin
        mem_op    = MemRead1_IN | MemWrite1_IN;
        is_store  = MemWrite1_IN;
        is_load   = MemRead1_IN & ~MemWrite1_IN;
        store_src = (MEM_Data_select == 2'd1) ? WB_result_forward : MemWriteData1_IN;
        timeout   = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT));
        // RESET gates the request path so it drops without waiting for a clock.
        req       = mem_op & ~misaligned & ~timeout & ~RESET;
        complete  = req & dmem_ack;
        pass      = mem_op ? complete : 1'b1;

        dmem_req   = req;
        dmem_we    = req & is_store;
        dmem_addr  = req ? {ALU_result1_IN[31:2], 2'b00} : '0;
        dmem_be    = req ? byte_en : '0;
        dmem_wdata = (req & is_store) ? store_lanes : '0;
        STALL_OUT  = req & ~dmem_ack;
        FAULT_OUT  = ~RESET & ((mem_op & misaligned) | timeout);
        Mem_result_forward = (complete & is_load) ? load_data : ALU_result1_IN;

        state_d = ST_IDLE;
        cnt_d   = '0;
        if (req && !dmem_ack) begin
            state_d = ST_WAIT;
            cnt_d   = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
        end

        instr_d    = '0;
        pc_d       = '0;
        wdata_d    = '0;
        wreg_d     = '0;
        regwrite_d = 1'b0;
        if (pass) begin
            instr_d    = Instr1_IN;
            pc_d       = Instr1_PC_IN;
            wdata_d    = Mem_result_forward;
            wreg_d     = WriteRegister1_IN;
            regwrite_d = RegWrite1_IN & ~is_store;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            wdata_q    <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            wdata_q    <= wdata_d;
            wreg_q     <= wreg_d;
            regwrite_q <= regwrite_d;
        end
    end

    assign Instr1_OUT         = instr_q;
    assign Instr1_PC_OUT      = pc_q;
    assign WriteData1_OUT     = wdata_q;
    assign WriteRegister1_OUT = wreg_q;
    assign RegWrite1_OUT      = regwrite_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected WB results queued at issue and
// popped whenever WB carries a real instruction; small byte-memory model.
module tb_mem_access;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic [31:0] instr, pc, alu, mwd, fwd, rdata;
        logic [4:0]  wreg;
        logic        rw, rd, wr;
        logic [5:0]  ctrl;
        logic [1:0]  sel;
    } op_t;

    typedef struct {
        logic [31:0] instr, pc, wdata;
        logic [4:0]  wreg;
        logic        rw;
    } exp_t;

    logic        CLK = 1'b0, RESET;
    logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN, WB_result_forward;
    logic [4:0]  WriteRegister1_IN;
    logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN, dmem_ack;
    logic [5:0]  ALU_Control1_IN;
    logic [1:0]  MEM_Data_select;
    logic [31:0] dmem_rdata;
    logic        dmem_req, dmem_we, STALL_OUT, FAULT_OUT, RegWrite1_OUT;
    logic [31:0] dmem_addr, dmem_wdata, Mem_result_forward;
    logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
    logic [3:0]  dmem_be;
    logic [4:0]  WriteRegister1_OUT;

    mem_access #(.TIMEOUT(TB_TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET),
        .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN), .ALU_result1_IN(ALU_result1_IN),
        .WriteRegister1_IN(WriteRegister1_IN), .MemWriteData1_IN(MemWriteData1_IN),
        .RegWrite1_IN(RegWrite1_IN), .ALU_Control1_IN(ALU_Control1_IN),
        .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
        .MEM_Data_select(MEM_Data_select), .WB_result_forward(WB_result_forward),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .STALL_OUT(STALL_OUT), .FAULT_OUT(FAULT_OUT), .Mem_result_forward(Mem_result_forward),
        .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT), .WriteData1_OUT(WriteData1_OUT),
        .WriteRegister1_OUT(WriteRegister1_OUT), .RegWrite1_OUT(RegWrite1_OUT)
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    logic [7:0]  mb[0:255];
    logic [31:0] mw[0:63];
    logic [31:0] last_addr, last_wdata, last_fwd;
    logic [3:0]  last_be;
    logic        last_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t make_op(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic [31:0] alu, input logic [4:0] wreg,
                                    input logic rw, input logic [5:0] ctrl, input logic rd,
                                    input logic wr, input logic [1:0] sel, input logic [31:0] mwd,
                                    input logic [31:0] fwd, input logic [31:0] rdata);
        op_t o;
        o.instr = instr; o.pc = pc; o.alu = alu; o.wreg = wreg; o.rw = rw; o.ctrl = ctrl;
        o.rd = rd; o.wr = wr; o.sel = sel; o.mwd = mwd; o.fwd = fwd; o.rdata = rdata;
        return o;
    endfunction

    task automatic set_inputs(input op_t o);
        Instr1_IN = o.instr; Instr1_PC_IN = o.pc; ALU_result1_IN = o.alu;
        WriteRegister1_IN = o.wreg; RegWrite1_IN = o.rw; ALU_Control1_IN = o.ctrl;
        MemRead1_IN = o.rd; MemWrite1_IN = o.wr; MEM_Data_select = o.sel;
        MemWriteData1_IN = o.mwd; WB_result_forward = o.fwd; dmem_rdata = o.rdata;
    endtask

    task automatic mem_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        if (a < 32'd256) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mw[a[7:2]][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    // Independent reference: byte-addressed big-endian memory.
    task automatic model_store(input logic [5:0] c, input logic [31:0] a, input logic [31:0] d);
        int i;
        i = int'(a[7:0]);
        if (c == 6'h28) mb[i] = d[7:0];
        else if (c == 6'h29) begin mb[i] = d[15:8]; mb[i+1] = d[7:0]; end
        else begin mb[i] = d[31:24]; mb[i+1] = d[23:16]; mb[i+2] = d[15:8]; mb[i+3] = d[7:0]; end
    endtask

    function automatic logic [31:0] model_load(input logic [5:0] c, input logic [31:0] a);
        int i;
        logic [7:0] b0, b1;
        i  = int'(a[7:0]);
        b0 = mb[i];
        b1 = mb[(i + 1) % 256];
        case (c)
            6'h20:   return {{24{b0[7]}}, b0};
            6'h24:   return {24'd0, b0};
            6'h21:   return {{16{b0[7]}}, b0, b1};
            6'h25:   return {16'd0, b0, b1};
            default: return {b0, b1, mb[(i + 2) % 256], mb[(i + 3) % 256]};
        endcase
    endfunction

    always @(negedge CLK) begin
        if (!RESET && Instr1_OUT != '0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_retire", Instr1_OUT, '0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wb_instr", Instr1_OUT, e.instr);
                check("wb_pc", Instr1_PC_OUT, e.pc);
                check("wb_data", WriteData1_OUT, e.wdata);
                check("wb_reg", 32'(WriteRegister1_OUT), 32'(e.wreg));
                check("wb_regwrite", 32'(RegWrite1_OUT), 32'(e.rw));
            end
        end
    end

    task automatic drive_op(input op_t o, input int ack_wait,
                            output int stalls, output int faults, output int reqs);
        logic done;
        done = 1'b0; stalls = 0; faults = 0; reqs = 0;
        last_addr = '0; last_be = '0; last_wdata = '0; last_we = 1'b0; last_fwd = '0;
        set_inputs(o);
        for (int k = 0; k < 40 && !done; k++) begin
            dmem_ack = (k == ack_wait);
            @(negedge CLK);
            if (dmem_req) begin
                if (reqs == 0) begin
                    last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata; last_we = dmem_we;
                end else begin
                    check("req_addr_stable", dmem_addr, last_addr);
                    check("req_wdata_stable", dmem_wdata, last_wdata);
                end
                reqs++;
                if (dmem_ack && dmem_we) mem_write(dmem_addr, dmem_be, dmem_wdata);
            end
            stalls += int'(STALL_OUT);
            faults += int'(FAULT_OUT);
            last_fwd = Mem_result_forward;
            done = !STALL_OUT;
            @(posedge CLK); #1;
        end
        if (!done) check("op_cycle_bound", 32'd0, 32'd1);
        dmem_ack = 1'b0;
        set_inputs(make_op('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0));
    endtask

    task automatic issue(input string tag, input op_t o, input int ack_wait, input logic retire,
                         input logic [31:0] exp_wdata, input int exp_stalls, input int exp_faults,
                         input int exp_reqs);
        int st, fl, rq;
        if (retire) sb_q.push_back('{instr: o.instr, pc: o.pc, wdata: exp_wdata,
                                      wreg: o.wreg, rw: o.rw & ~o.wr});
        drive_op(o, ack_wait, st, fl, rq);
        check({tag, "_stalls"}, 32'(st), 32'(exp_stalls));
        check({tag, "_faults"}, 32'(fl), 32'(exp_faults));
        check({tag, "_reqs"}, 32'(rq), 32'(exp_reqs));
        if (!retire) begin
            check({tag, "_bubble_instr"}, Instr1_OUT, '0);
            check({tag, "_bubble_rw"}, 32'(RegWrite1_OUT), 32'd0);
        end
    endtask

    initial begin
        op_t o;
        logic [5:0] codes[8];
        codes = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B};
        for (int i = 0; i < 256; i++) mb[i] = '0;
        for (int i = 0; i < 64; i++) mw[i] = '0;
        RESET = 1'b1; dmem_ack = 1'b0;
        set_inputs(make_op('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0));
        @(posedge CLK); #1;
        check("rst_instr", Instr1_OUT, '0);
        check("rst_pc", Instr1_PC_OUT, '0);
        check("rst_wdata", WriteData1_OUT, '0);
        check("rst_wreg", 32'(WriteRegister1_OUT), 32'd0);
        check("rst_rw", 32'(RegWrite1_OUT), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_stall", 32'(STALL_OUT), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        o = make_op(32'h0085_2820, 32'h0040_0000, 32'h0000_1234, 5'd5, 1'b1, 6'h20, 1'b0, 1'b0, 2'd0, '0, '0, '0);
        issue("add", o, 0, 1'b1, 32'h0000_1234, 0, 0, 0);
        check("add_fwd", last_fwd, 32'h0000_1234);

        o = make_op(32'h8083_0003, 32'h0040_0004, 32'h0000_0103, 5'd7, 1'b1, 6'h20, 1'b1, 1'b0, 2'd0, '0, '0, 32'h1122_3380);
        issue("lb", o, 2, 1'b1, 32'hFFFF_FF80, 2, 0, 3);
        check("lb_fwd", last_fwd, 32'hFFFF_FF80);
        check("lb_addr", last_addr, 32'h0000_0100);
        check("lb_be", 32'(last_be), 32'h1);
        o.instr = 32'h9083_0003; o.ctrl = 6'h24;
        issue("lbu", o, 2, 1'b1, 32'h0000_0080, 2, 0, 3);

        o = make_op(32'hA483_0002, 32'h0040_000C, 32'h0000_0202, 5'd9, 1'b1, 6'h29, 1'b0, 1'b1, 2'd1,
                    32'h0000_ABCD, 32'h0000_BEEF, '0);
        issue("sh", o, 0, 1'b1, 32'h0000_0202, 0, 0, 1);
        check("sh_addr", last_addr, 32'h0000_0200);
        check("sh_be", 32'(last_be), 32'h3);
        check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        check("sh_we", 32'(last_we), 32'd1);

        o = make_op(32'h8C83_0001, 32'h0040_0010, 32'h0000_0301, 5'd3, 1'b1, 6'h23, 1'b1, 1'b0, 2'd0, '0, '0, '0);
        issue("lw_misalign", o, 0, 1'b0, '0, 0, 1, 0);
        o.ctrl = 6'h21; o.alu = 32'h0000_0105;
        issue("lh_misalign", o, 0, 1'b0, '0, 0, 1, 0);

        o = make_op(32'h8C84_0000, 32'h0040_0014, 32'h0000_0040, 5'd4, 1'b1, 6'h23, 1'b1, 1'b0, 2'd0, '0, '0, 32'h1357_9BDF);
        issue("lw_timeout", o, -1, 1'b0, '0, TB_TIMEOUT + 1, 1, TB_TIMEOUT + 1);
        issue("lw_last_ack", o, TB_TIMEOUT, 1'b1, 32'h1357_9BDF, TB_TIMEOUT, 0, TB_TIMEOUT + 1);

        for (int n = 0; n < 24; n++) begin
            logic [5:0]  c;
            logic [1:0]  off, sel;
            logic [31:0] a, mwd, fwd, d;
            int          aw;
            c   = codes[$urandom_range(0, 7)];
            off = (c == 6'h20 || c == 6'h24 || c == 6'h28) ? 2'($urandom_range(0, 3)) :
                  (c == 6'h21 || c == 6'h25 || c == 6'h29) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
            a   = 32'($urandom_range(0, 7)) * 32'd4 + 32'(off);
            sel = 2'($urandom_range(0, 1));
            mwd = $urandom; fwd = $urandom;
            aw  = $urandom_range(0, 3);
            o = make_op(32'h1000_0000 + 32'(n), 32'h0040_1000 + 32'(n * 4), a, 5'($urandom_range(1, 31)),
                        1'b1, c, ~c[3], c[3], sel, mwd, fwd, mw[a[7:2]]);
            if (c[3]) begin
                d = (sel == 2'd1) ? fwd : mwd;
                model_store(c, a, d);
                issue("rnd_store", o, aw, 1'b1, a, aw, 0, aw + 1);
            end else begin
                issue("rnd_load", o, aw, 1'b1, model_load(c, a), aw, 0, aw + 1);
            end
        end

        o = make_op(32'h8C85_0000, 32'h0040_0020, 32'h0000_0080, 5'd6, 1'b1, 6'h23, 1'b1, 1'b0, 2'd0, '0, '0, 32'hDEAD_0001);
        set_inputs(o);
        dmem_ack = 1'b0;
        @(posedge CLK); #1;
        check("wait_req_before_rst", 32'(dmem_req), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("rst_async_req", 32'(dmem_req), 32'd0);
        check("rst_async_stall", 32'(STALL_OUT), 32'd0);
        set_inputs(make_op('0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0));
        @(posedge CLK); #1;
        RESET = 1'b0;
        dmem_ack = 1'b1;
        @(negedge CLK);
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_stall", 32'(STALL_OUT), 32'd0);
        @(posedge CLK); #1;
        dmem_ack = 1'b0;
        check("late_ack_bubble", Instr1_OUT, '0);
        o.instr = 32'h8C86_0000; o.alu = 32'h0000_0084; o.rdata = 32'hCAFE_F00D;
        issue("post_rst_lw", o, 1, 1'b1, 32'hCAFE_F00D, 1, 0, 2);

        repeat (3) @(posedge CLK);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
